// File: rtl/rte_rx_deframer_pkg.sv
// ---------------------------------------------------------------------------
// rte_rx_deframer_pkg
//   Shared definitions for the RTE receive deframer and the MAC transmit side:
//   deframer state encoding, header field positions and the header -> frame
//   length decode.
// ---------------------------------------------------------------------------
package rte_rx_deframer_pkg;

    localparam int unsigned WORD_W   = 33;
    localparam int unsigned SOF_BIT  = 32;
    localparam int unsigned TYPE_MSB = 18;
    localparam int unsigned TYPE_LSB = 16;
    localparam int unsigned SIZE_MSB = 23;
    localparam int unsigned SIZE_LSB = 22;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RECV = ST_RECV,
        S_DROP = ST_DROP
    } state_e;

    // Total frame length in words (header included), 1..6.
    function automatic logic [2:0] frame_len(input logic [WORD_W-1:0] hdr);
        logic [2:0] typ;
        logic [1:0] sz;
        logic [2:0] len;
        typ = hdr[TYPE_MSB:TYPE_LSB];
        sz  = hdr[SIZE_MSB:SIZE_LSB];
        case (typ)
            3'd0:    len = (sz == 2'd3) ? 3'd6 : (sz == 2'd2) ? 3'd5 : 3'd4;
            3'd1:    len = 3'd4;
            3'd2:    len = (sz == 2'd3) ? 3'd4 : (sz == 2'd2) ? 3'd3 : 3'd2;
            3'd3:    len = 3'd2;
            3'd4:    len = 3'd5;
            3'd5:    len = 3'd2;
            3'd6:    len = (sz == 2'd3) ? 3'd3 : 3'd2;
            default: len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rte_rx_deframer_fifo.sv
// ---------------------------------------------------------------------------
// rte_commit_fifo
//   Single-clock store-and-forward buffer. Words are written speculatively at
//   the write pointer and only become visible to the reader once committed;
//   a rollback returns the write pointer to the committed pointer.
//
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     flush_i         synchronous clear of all pointers
//     wr_en_i         write wr_data_i (after any same-cycle rollback)
//     commit_i        publish everything written so far, incl. this write
//     rollback_i      discard uncommitted words before this cycle's write
//     rd_en_i         pop the word at the read pointer
//     rd_data_o       word at the read pointer
//     rd_avail_o      at least one committed, unread word
//     full_o          buffer holds DEPTH words and no read this cycle
//     full_cmt_o      as full_o, measured from the committed pointer
// ---------------------------------------------------------------------------
module rte_commit_fifo
    import rte_rx_deframer_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned W     = WORD_W + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         commit_i,
    input  logic         rollback_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         rd_avail_o,
    output logic         full_o,
    output logic         full_cmt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d, wr_base;
    logic [W-1:0] mem_q [DEPTH];

    function automatic logic ptr_full(input logic [AW:0] a, input logic [AW:0] b);
        return (a[AW] != b[AW]) && (a[AW-1:0] == b[AW-1:0]);
    endfunction

    // A rollback and a write in the same cycle restart at the committed pointer.
    assign wr_base = rollback_i ? cmt_q : wr_q;

    always_comb begin
        wr_d  = wr_en_i ? wr_base + 1'b1 : wr_base;
        cmt_d = commit_i ? wr_d : cmt_q;
        rd_d  = rd_en_i ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            cmt_q <= '0;
            rd_q  <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            cmt_q <= '0;
            rd_q  <= '0;
        end else begin
            wr_q  <= wr_d;
            cmt_q <= cmt_d;
            rd_q  <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !flush_i) begin
            mem_q[wr_base[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_q[AW-1:0]];
    assign rd_avail_o = (cmt_q != rd_q);
    // A read this cycle frees a slot, so a same-cycle write is still allowed.
    assign full_o     = ptr_full(wr_q, rd_q) && !rd_en_i;
    assign full_cmt_o = ptr_full(cmt_q, rd_q) && !rd_en_i;

endmodule

// File: rtl/rte_rx_deframer.sv
// ---------------------------------------------------------------------------
// rte_rx_deframer
//   Reassembles header-delimited frames from the MAC receive word stream,
//   buffers each frame until complete and forwards it on a registered
//   strobe/accept interface. Partial frames are discarded on a new header,
//   on buffer overflow and (with statistics built) on an idle timeout.
//
//   Build option: define RTE_DEFRAMER_STATS_EN to build the idle timeout and
//   the DROPCNT/ORPHCNT counters; otherwise both counters read 0 and a frame
//   in progress waits indefinitely.
//
//   Ports:
//     CLK      clock (rising edge)
//     RST      asynchronous active-low reset
//     ENA      enable; low flushes buffer and state, counters hold
//     RXSTB    input word strobe
//     RXD      input word, bit 32 = start of frame
//     OSTB     output word valid
//     OACK     consumer accept
//     ODAT     output word
//     OLAST    last word of a frame
//     BUSY     frame assembly in progress
//     DROPCNT  aborted frames (saturating)
//     ORPHCNT  words received outside any frame (saturating)
// ---------------------------------------------------------------------------
module rte_rx_deframer
    import rte_rx_deframer_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENA,
    input  logic              RXSTB,
    input  logic [WORD_W-1:0] RXD,
    output logic              OSTB,
    input  logic              OACK,
    output logic [WORD_W-1:0] ODAT,
    output logic              OLAST,
    output logic              BUSY,
    output logic [15:0]       DROPCNT,
    output logic [15:0]       ORPHCNT
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        hdr_len;
    logic              sof;
    logic              wr_en, commit, rollback, start_ok;
    logic              drop_inc, orph_inc, tmo_exp;
    logic              rd_en, rd_avail, full_wr, full_cmt;
    logic [WORD_W:0]   rd_data;
    logic              ostb_q, ostb_d, olast_q, olast_d;
    logic [WORD_W-1:0] odat_q, odat_d;

    assign sof     = RXD[SOF_BIT];
    assign hdr_len = frame_len(RXD);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        start_ok = 1'b0;
        drop_inc = 1'b0;
        orph_inc = 1'b0;

        case (state_q)
            S_RECV: begin
                if (RXSTB) begin
                    if (sof) begin
                        rollback = 1'b1;
                        drop_inc = 1'b1;
                        start_ok = !full_cmt;
                        if (full_cmt) begin
                            state_d = S_DROP;
                        end
                    end else if (full_wr) begin
                        rollback = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = S_DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (cnt_q == 3'd1) begin
                            commit  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end else if (tmo_exp) begin
                    rollback = 1'b1;
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                // IDLE and DROP both accept a header; wr == cmt here so no
                // rollback is needed before writing it.
                if (RXSTB) begin
                    if (sof) begin
                        if (full_wr) begin
                            drop_inc = 1'b1;
                            state_d  = S_DROP;
                        end else begin
                            start_ok = 1'b1;
                        end
                    end else if (state_q == S_IDLE) begin
                        orph_inc = 1'b1;
                    end
                end
            end
        endcase

        if (start_ok) begin
            wr_en = 1'b1;
            if (hdr_len == 3'd1) begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d   = hdr_len - 3'd1;
                state_d = S_RECV;
            end
        end

        if (!ENA) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            wr_en    = 1'b0;
            commit   = 1'b0;
            rollback = 1'b0;
            drop_inc = 1'b0;
            orph_inc = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    rte_commit_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W + 1)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .flush_i    (!ENA),
        .wr_en_i    (wr_en),
        .wr_data_i  ({commit, RXD}),
        .commit_i   (commit),
        .rollback_i (rollback),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .rd_avail_o (rd_avail),
        .full_o     (full_wr),
        .full_cmt_o (full_cmt)
    );

    // Output register reloads when empty or when the current word is taken.
    assign rd_en = ENA && rd_avail && (!ostb_q || OACK);

    always_comb begin
        ostb_d  = ostb_q;
        odat_d  = odat_q;
        olast_d = olast_q;
        if (rd_en) begin
            ostb_d  = 1'b1;
            odat_d  = rd_data[WORD_W-1:0];
            olast_d = rd_data[WORD_W];
        end else if (OACK) begin
            ostb_d = 1'b0;
        end
        if (!ENA) begin
            ostb_d  = 1'b0;
            odat_d  = '0;
            olast_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ostb_q  <= 1'b0;
            odat_q  <= '0;
            olast_q <= 1'b0;
        end else begin
            ostb_q  <= ostb_d;
            odat_q  <= odat_d;
            olast_q <= olast_d;
        end
    end

    assign OSTB  = ostb_q;
    assign ODAT  = odat_q;
    assign OLAST = olast_q;
    assign BUSY  = (state_q == S_RECV);

`ifdef RTE_DEFRAMER_STATS_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] drop_q, orph_q;

    // Counts consecutive strobe-less cycles spent in RECV; any other cycle
    // restarts it, so a frame entered from any state starts at zero.
    always_comb begin
        tmo_d = '0;
        if (ENA && state_q == S_RECV && !RXSTB) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    assign tmo_exp = (state_q == S_RECV) && !RXSTB && (tmo_q == TMO_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_q  <= '0;
            drop_q <= '0;
            orph_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            if (drop_inc && drop_q != '1) begin
                drop_q <= drop_q + 16'd1;
            end
            if (orph_inc && orph_q != '1) begin
                orph_q <= orph_q + 16'd1;
            end
        end
    end

    assign DROPCNT = drop_q;
    assign ORPHCNT = orph_q;
`else
    logic unused_stats;

    assign tmo_exp      = 1'b0;
    assign DROPCNT      = '0;
    assign ORPHCNT      = '0;
    assign unused_stats = drop_inc | orph_inc | (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_rte_rx_deframer.sv
`timescale 1ns/1ps
module tb_rte_rx_deframer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 255;
`ifdef RTE_DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, ENA, RXSTB, OACK;
    logic [32:0] RXD;
    logic        OSTB, OLAST, BUSY;
    logic [32:0] ODAT;
    logic [15:0] DROPCNT, ORPHCNT;

    always #5 CLK = ~CLK;

    rte_rx_deframer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENA     (ENA),
        .RXSTB   (RXSTB),
        .RXD     (RXD),
        .OSTB    (OSTB),
        .OACK    (OACK),
        .ODAT    (ODAT),
        .OLAST   (OLAST),
        .BUSY    (BUSY),
        .DROPCNT (DROPCNT),
        .ORPHCNT (ORPHCNT)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: frames as queues of words.
    logic [33:0] exp_q[$];   // {last, word} committed, not yet consumed
    logic [32:0] part_q[$];  // frame being assembled
    int unsigned rem, idle, m_drop, m_orph;
    int unsigned words_out, cur_len, last_len;
    bit          stall_prev;
    logic [33:0] out_prev;

    typedef struct {
        logic [2:0]  typ;
        logic [1:0]  sz;
        int unsigned len;
    } len_vec_t;
    len_vec_t tbl[14];

    function automatic int unsigned ref_len(input logic [32:0] h);
        logic [2:0] t;
        logic [1:0] s;
        t = h[18:16];
        s = h[23:22];
        case (t)
            3'd0: return (s == 2'd0 || s == 2'd1) ? 4 : (s == 2'd2) ? 5 : 6;
            3'd1: return 4;
            3'd2: return (s == 2'd0 || s == 2'd1) ? 2 : (s == 2'd2) ? 3 : 4;
            3'd3: return 2;
            3'd4: return 5;
            3'd5: return 2;
            3'd6: return (s == 2'd3) ? 3 : 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] cnt_exp(input int unsigned n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [32:0] mk_hdr(input logic [2:0] t, input logic [1:0] s, input logic [7:0] tag);
        logic [32:0] w;
        w        = '0;
        w[32]    = 1'b1;
        w[31:24] = tag;
        w[23:22] = s;
        w[18:16] = t;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic commit_part();
        for (int i = 0; i < part_q.size(); i++) begin
            exp_q.push_back({(i == part_q.size() - 1), part_q[i]});
        end
        part_q.delete();
    endtask

    task automatic model_word(input logic [32:0] w);
        if (w[32]) begin
            if (part_q.size() != 0) begin
                m_drop++;
                part_q.delete();
            end
            part_q.push_back(w);
            rem  = ref_len(w) - 1;
            idle = 0;
            if (rem == 0) commit_part();
        end else if (part_q.size() != 0) begin
            part_q.push_back(w);
            rem--;
            idle = 0;
            if (rem == 0) commit_part();
        end else begin
            m_orph++;
        end
    endtask

    task automatic model_idle();
        if (part_q.size() != 0) begin
            idle++;
            if (STATS && idle == TIMEOUT) begin
                m_drop++;
                part_q.delete();
            end
        end
    endtask

    // One clock: drive inputs for the next rising edge and score the output
    // transfer that edge will perform.
    task automatic cycle(input bit stb, input logic [32:0] d, input bit ack, input bit upd);
        logic [33:0] e;
        @(negedge CLK);
        if (stall_prev) begin
            check("hold_ostb", OSTB, 1);
            check("hold_data", {OLAST, ODAT}, out_prev);
        end
        RXSTB = stb;
        RXD   = d;
        OACK  = ack;
        if (OSTB && OACK) begin
            words_out++;
            cur_len++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got 0x%0h, want none", ODAT);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {OLAST, ODAT}, e);
            end
            if (OLAST) begin
                last_len = cur_len;
                cur_len  = 0;
            end
        end
        stall_prev = OSTB && !OACK;
        out_prev   = {OLAST, ODAT};
        if (upd) begin
            if (stb) model_word(d);
            else     model_idle();
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || OSTB) && n < 300) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words pending, want 0", exp_q.size());
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic do_flush();
        @(negedge CLK);
        RXSTB = 1'b0;
        OACK  = 1'b0;
        ENA   = 1'b0;
        @(negedge CLK);
        ENA = 1'b1;
        exp_q.delete();
        part_q.delete();
        idle       = 0;
        cur_len    = 0;
        stall_prev = 1'b0;
        check("flush_ostb", OSTB, 0);
        check("flush_busy", BUSY, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int unsigned w0;
        logic [32:0] w;
        bit stb, ack;

        tbl[0]  = '{3'd0, 2'd0, 4};  tbl[1]  = '{3'd0, 2'd1, 4};
        tbl[2]  = '{3'd0, 2'd2, 5};  tbl[3]  = '{3'd0, 2'd3, 6};
        tbl[4]  = '{3'd1, 2'd2, 4};  tbl[5]  = '{3'd2, 2'd0, 2};
        tbl[6]  = '{3'd2, 2'd2, 3};  tbl[7]  = '{3'd2, 2'd3, 4};
        tbl[8]  = '{3'd3, 2'd1, 2};  tbl[9]  = '{3'd4, 2'd0, 5};
        tbl[10] = '{3'd5, 2'd3, 2};  tbl[11] = '{3'd6, 2'd1, 2};
        tbl[12] = '{3'd6, 2'd3, 3};  tbl[13] = '{3'd7, 2'd2, 1};

        rem = 0; idle = 0; m_drop = 0; m_orph = 0;
        words_out = 0; cur_len = 0; last_len = 0;
        stall_prev = 1'b0; out_prev = '0;

        RST = 1'b0; ENA = 1'b1; RXSTB = 1'b0; RXD = '0; OACK = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ostb", OSTB, 0);
        check("rst_odat", ODAT, 0);
        check("rst_olast", OLAST, 0);
        check("rst_busy", BUSY, 0);
        check("rst_dropcnt", DROPCNT, 0);
        check("rst_orphcnt", ORPHCNT, 0);
        RST = 1'b1;

        // Length decode: one frame per table entry, length taken from the table.
        foreach (tbl[i]) begin
            w0 = words_out;
            cycle(1'b1, mk_hdr(tbl[i].typ, tbl[i].sz, 8'(i)), 1'b1, 1'b1);
            for (int k = 1; k < tbl[i].len; k++) begin
                cycle(1'b1, {1'b0, 32'(i * 256 + k)}, 1'b1, 1'b1);
            end
            drain();
            check("len_words", words_out - w0, tbl[i].len);
            check("len_olast", last_len, tbl[i].len);
        end

        // Type 3 frame from a literal header.
        w0 = words_out;
        cycle(1'b1, 33'h1_0003_0000, 1'b1, 1'b1);
        cycle(1'b1, 33'h0_DEAD_BEEF, 1'b1, 1'b1);
        drain();
        check("t3_words", words_out - w0, 2);
        check("t3_olast", last_len, 2);
        check("t3_dropcnt", DROPCNT, 0);

        // Partial frame interrupted by a single-word header.
        w0 = words_out;
        cycle(1'b1, mk_hdr(3'd0, 2'd3, 8'hA0), 1'b1, 1'b1);
        cycle(1'b1, 33'h0_0000_0001, 1'b1, 1'b1);
        cycle(1'b1, 33'h0_0000_0002, 1'b1, 1'b1);
        cycle(1'b1, mk_hdr(3'd7, 2'd0, 8'hA1), 1'b1, 1'b1);
        drain();
        check("restart_dropcnt", DROPCNT, cnt_exp(m_drop));
        check("restart_words", words_out - w0, 1);
        check("restart_olast", last_len, 1);

        // Idle timeout inside a frame.
        w0 = words_out;
        cycle(1'b1, mk_hdr(3'd4, 2'd0, 8'hB0), 1'b1, 1'b1);
        cycle(1'b1, 33'h0_0000_0011, 1'b1, 1'b1);
        cycle(1'b1, 33'h0_0000_0012, 1'b1, 1'b1);
        for (int k = 0; k < TIMEOUT; k++) cycle(1'b0, '0, 1'b1, 1'b1);
        check("tmo_busy_before", BUSY, 1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("tmo_busy_after", BUSY, (part_q.size() != 0));
        check("tmo_dropcnt", DROPCNT, cnt_exp(m_drop));
        check("tmo_words", words_out - w0, 0);
        do_flush();

        // Overflow with a stalled consumer.
        w0 = words_out;
        cycle(1'b1, mk_hdr(3'd4, 2'd0, 8'hC0), 1'b0, 1'b0);
        exp_q.push_back({1'b0, mk_hdr(3'd4, 2'd0, 8'hC0)});
        for (int k = 1; k < 5; k++) begin
            cycle(1'b1, {1'b0, 32'(16'hC000 + k)}, 1'b0, 1'b0);
            exp_q.push_back({(k == 4), 1'b0, 32'(16'hC000 + k)});
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, mk_hdr(3'd4, 2'd0, 8'hC1), 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) cycle(1'b1, {1'b0, 32'(16'hC100 + k)}, 1'b0, 1'b0);
        m_drop++;
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("full_busy", BUSY, 0);
        check("full_dropcnt", DROPCNT, cnt_exp(m_drop));
        cycle(1'b1, mk_hdr(3'd5, 2'd0, 8'hC2), 1'b0, 1'b1);
        cycle(1'b1, 33'h0_0000_C201, 1'b0, 1'b1);
        drain();
        check("full_words", words_out - w0, 7);
        check("full_olast", last_len, 2);

        // Orphan words while idle.
        w0 = words_out;
        for (int k = 0; k < 3; k++) cycle(1'b1, {1'b0, 32'(k + 5)}, 1'b1, 1'b1);
        drain();
        check("orph_cnt", ORPHCNT, cnt_exp(m_orph));
        check("orph_words", words_out - w0, 0);

        // Randomized traffic; input is throttled so the buffer cannot fill.
        for (int c = 0; c < 1500; c++) begin
            ack = ($urandom_range(0, 3) != 0);
            stb = ($urandom_range(0, 1) == 1) && (exp_q.size() + part_q.size() < DEPTH - 1);
            w   = {1'b0, 32'($urandom)};
            if (part_q.size() == 0) w[32] = ($urandom_range(0, 9) != 0);
            else                    w[32] = ($urandom_range(0, 7) == 0);
            cycle(stb, w, ack, 1'b1);
        end
        drain();
        check("rand_dropcnt", DROPCNT, cnt_exp(m_drop));
        check("rand_orphcnt", ORPHCNT, cnt_exp(m_orph));
        check("rand_pending", exp_q.size(), 0);

        // Reset with a committed frame pending and a partial frame open.
        cycle(1'b1, mk_hdr(3'd5, 2'd1, 8'hD0), 1'b0, 1'b1);
        cycle(1'b1, 33'h0_0000_D001, 1'b0, 1'b1);
        cycle(1'b1, mk_hdr(3'd4, 2'd0, 8'hD1), 1'b0, 1'b1);
        cycle(1'b1, 33'h0_0000_D101, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("arst_ostb", OSTB, 0);
        check("arst_busy", BUSY, 0);
        check("arst_dropcnt", DROPCNT, 0);
        check("arst_orphcnt", ORPHCNT, 0);
        @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
        part_q.delete();
        idle = 0; m_drop = 0; m_orph = 0; cur_len = 0;
        stall_prev = 1'b0;
        w0 = words_out;
        for (int k = 0; k < 20; k++) cycle(1'b0, '0, 1'b1, 1'b1);
        check("arst_no_stale", words_out - w0, 0);
        cycle(1'b1, 33'h1_0003_0000, 1'b1, 1'b1);
        cycle(1'b1, 33'h0_1234_5678, 1'b1, 1'b1);
        drain();
        check("arst_new_words", words_out - w0, 2);
        check("arst_new_olast", last_len, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
